// File: rtl/apb_master_arbiter.sv
// ============================================================================
// Module   : apb_master_arbiter
// Purpose  : Round-robin arbiter plus APB master sequencer. Shares a single
//            APB slave between N local requesters using a req/gnt/done
//            handshake. One APB transfer is in flight at a time; a new
//            transfer may be granted on the same edge the previous one
//            completes, so back-to-back traffic has no idle cycle.
// Ports    : PCLK, PRESETn       - clock (rising edge), async active-low reset
//            req/req_write       - per-requester request and direction
//            req_addr/req_wdata  - packed per-requester address / write data
//            gnt/done            - one-hot single-cycle grant / completion
//            rdata/err           - read data and timeout flag (done cycle)
//            PSEL..PREADY        - APB master interface
// Options  : APB_TIMEOUT_EN      - when defined, a transfer whose PREADY
//                                  stays low for TIMEOUT_CYCLES ACCESS
//                                  cycles completes with err = 1, rdata = 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module apb_master_arbiter #(
  parameter int N              = 2,
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic            PCLK,
  input  logic            PRESETn,
  input  logic [N-1:0]    req,
  input  logic [N-1:0]    req_write,
  input  logic [N*AW-1:0] req_addr,
  input  logic [N*DW-1:0] req_wdata,
  output logic [N-1:0]    gnt,
  output logic [N-1:0]    done,
  output logic [DW-1:0]   rdata,
  output logic            err,
  output logic            PSEL,
  output logic            PENABLE,
  output logic            PWRITE,
  output logic [AW-1:0]   PADDR,
  output logic [DW-1:0]   PWDATA,
  input  logic [DW-1:0]   PRDATA,
  input  logic            PREADY
);

  localparam int LW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_ACCESS = 2'd2;

  logic [1:0]    r_state;
  logic [LW-1:0] r_last;     // last granted requester; also owner of the transfer in flight
  logic [N-1:0]  r_gnt;
  logic [N-1:0]  r_done;
  logic [DW-1:0] r_rdata;
  logic          r_psel;
  logic          r_penable;
  logic          r_pwrite;
  logic [AW-1:0] r_paddr;
  logic [DW-1:0] r_pwdata;

  logic [LW-1:0] w_win;
  logic          w_found;
  logic          w_grant;
  int            w_idx;

  // Round-robin search starting just after the last winner, so the most
  // recently served requester has the lowest priority.
  always_comb begin
    w_win   = '0;
    w_found = 1'b0;
    w_idx   = 0;
    for (int k = 1; k <= N; k++) begin
      w_idx = (int'(r_last) + k) % N;
      if (!w_found && req[w_idx]) begin
        w_found = 1'b1;
        w_win   = w_idx[LW-1:0];
      end
    end
  end

`ifdef APB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] r_cnt;
  logic          r_err;
  logic          w_tmo;

  // Expires on the edge where the wait count would reach TIMEOUT_CYCLES.
  assign w_tmo = (r_state == S_ACCESS) && !PREADY &&
                 (r_cnt == CW'(TIMEOUT_CYCLES - 1));
`endif

  // Arbitration happens from IDLE, or on the completing ACCESS edge so the
  // next transfer's SETUP immediately follows the previous ACCESS.
  assign w_grant = w_found &&
                   ((r_state == S_IDLE) || ((r_state == S_ACCESS) && PREADY));

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state   <= S_IDLE;
      r_last    <= LW'(N - 1);
      r_gnt     <= '0;
      r_done    <= '0;
      r_rdata   <= '0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
      r_paddr   <= '0;
      r_pwdata  <= '0;
`ifdef APB_TIMEOUT_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
`endif
    end else begin
      r_gnt  <= '0;
      r_done <= '0;
`ifdef APB_TIMEOUT_EN
      r_err  <= 1'b0;
`endif
      case (r_state)
        S_IDLE: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
        end
        S_SETUP: begin
          r_penable <= 1'b1;
          r_state   <= S_ACCESS;
`ifdef APB_TIMEOUT_EN
          r_cnt     <= '0;
`endif
        end
        S_ACCESS: begin
          if (PREADY) begin
            r_done[r_last] <= 1'b1;
            if (!r_pwrite) begin
              r_rdata <= PRDATA;
            end
            // Return to IDLE unless the grant block below re-arbitrates.
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_state   <= S_IDLE;
          end
`ifdef APB_TIMEOUT_EN
          else if (w_tmo) begin
            r_done[r_last] <= 1'b1;
            r_err          <= 1'b1;
            r_rdata        <= '0;
            r_psel         <= 1'b0;
            r_penable      <= 1'b0;
            r_state        <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
`endif
        end
        default: begin
          r_psel    <= 1'b0;
          r_penable <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase

      // Placed after the state case so a grant overrides the return to IDLE
      // on a completing edge.
      if (w_grant) begin
        r_gnt[w_win] <= 1'b1;
        r_last       <= w_win;
        r_psel       <= 1'b1;
        r_penable    <= 1'b0;
        r_pwrite     <= req_write[w_win];
        r_paddr      <= req_addr[w_win*AW +: AW];
        r_pwdata     <= req_wdata[w_win*DW +: DW];
        r_state      <= S_SETUP;
      end
    end
  end

  assign gnt     = r_gnt;
  assign done    = r_done;
  assign rdata   = r_rdata;
  assign PSEL    = r_psel;
  assign PENABLE = r_penable;
  assign PWRITE  = r_pwrite;
  assign PADDR   = r_paddr;
  assign PWDATA  = r_pwdata;
`ifdef APB_TIMEOUT_EN
  assign err     = r_err;
`else
  assign err     = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
// ============================================================================
// Module   : tb_apb_master_arbiter
// Purpose  : Directed self-checking bench for apb_master_arbiter (N = 2).
//            Outputs are sampled 1 time unit after each rising clock edge;
//            inputs are changed at the same point, well before the next edge.
// Options  : APB_TIMEOUT_EN - also runs the PREADY timeout scenario.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_apb_master_arbiter;

  localparam int N  = 2;
  localparam int AW = 32;
  localparam int DW = 32;

  logic            clk;
  logic            rst_n;
  logic [N-1:0]    req;
  logic [N-1:0]    req_write;
  logic [AW-1:0]   a0, a1;
  logic [DW-1:0]   d0, d1;
  logic [N-1:0]    gnt, done;
  logic [DW-1:0]   rdata;
  logic            err;
  logic            psel, penable, pwrite;
  logic [AW-1:0]   paddr;
  logic [DW-1:0]   pwdata;
  logic [DW-1:0]   prdata;
  logic            pready;

  int checks   = 0;
  int failures = 0;

  apb_master_arbiter #(.N(N), .AW(AW), .DW(DW), .TIMEOUT_CYCLES(16)) dut (
    .PCLK      (clk),
    .PRESETn   (rst_n),
    .req       (req),
    .req_write (req_write),
    .req_addr  ({a1, a0}),
    .req_wdata ({d1, d0}),
    .gnt       (gnt),
    .done      (done),
    .rdata     (rdata),
    .err       (err),
    .PSEL      (psel),
    .PENABLE   (penable),
    .PWRITE    (pwrite),
    .PADDR     (paddr),
    .PWDATA    (pwdata),
    .PRDATA    (prdata),
    .PREADY    (pready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_write = '0;
    a0 = '0; a1 = '0; d0 = '0; d1 = '0;
    prdata = '0; pready = 1'b1;
    #12;
    // ---- reset state ----
    chk("rst_psel", 32'(psel), 32'h0);
    chk("rst_penable", 32'(penable), 32'h0);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_paddr", paddr, 32'h0);
    rst_n = 1'b1;

    // ---- single write, requester 0 ----
    req = 2'b01; req_write = 2'b01; a0 = 32'h10; d0 = 32'hDEADBEEF;
    tick();
    chk("wr_gnt", 32'(gnt), 32'h1);
    chk("wr_setup_psel", 32'(psel), 32'h1);
    chk("wr_setup_pen", 32'(penable), 32'h0);
    chk("wr_paddr", paddr, 32'h10);
    chk("wr_pwdata", pwdata, 32'hDEADBEEF);
    chk("wr_pwrite", 32'(pwrite), 32'h1);
    req = 2'b00;
    tick();
    chk("wr_acc_pen", 32'(penable), 32'h1);
    chk("wr_acc_gnt", 32'(gnt), 32'h0);
    chk("wr_acc_done", 32'(done), 32'h0);
    tick();
    chk("wr_done", 32'(done), 32'h1);
    chk("wr_err", 32'(err), 32'h0);
    chk("wr_idle_psel", 32'(psel), 32'h0);

    // ---- readback, requester 0 ----
    req = 2'b01; req_write = 2'b00; a0 = 32'h10; prdata = 32'hDEADBEEF;
    tick();
    chk("rd_gnt", 32'(gnt), 32'h1);
    chk("rd_pwrite", 32'(pwrite), 32'h0);
    req = 2'b00;
    tick();
    chk("rd_pen", 32'(penable), 32'h1);
    tick();
    chk("rd_done", 32'(done), 32'h1);
    chk("rd_rdata", rdata, 32'hDEADBEEF);
    prdata = 32'h0;

    // ---- a write leaves rdata unchanged ----
    req = 2'b01; req_write = 2'b01; a0 = 32'h14; d0 = 32'h11112222;
    tick();
    req = 2'b00;
    tick();
    tick();
    chk("wr2_done", 32'(done), 32'h1);
    chk("wr2_rdata_hold", rdata, 32'hDEADBEEF);

    // ---- PREADY stall for 5 ACCESS cycles, requester 1 ----
    req = 2'b10; req_write = 2'b10; a1 = 32'h44; d1 = 32'h12345678; pready = 1'b0;
    tick();
    chk("st_gnt", 32'(gnt), 32'h2);
    req = 2'b00;
    tick();
    chk("st_pen", 32'(penable), 32'h1);
    for (int i = 0; i < 5; i++) begin
      tick();
      chk($sformatf("st_paddr_%0d", i), paddr, 32'h44);
      chk($sformatf("st_pwdata_%0d", i), pwdata, 32'h12345678);
      chk($sformatf("st_pwrite_%0d", i), 32'(pwrite), 32'h1);
      chk($sformatf("st_penable_%0d", i), 32'(penable), 32'h1);
      chk($sformatf("st_done_%0d", i), 32'(done), 32'h0);
    end
    pready = 1'b1;
    tick();
    chk("st_done", 32'(done), 32'h2);
    tick();
    chk("st_idle_psel", 32'(psel), 32'h0);

    // ---- fresh reset: req[1] alone, then both -> requester 0 wins ----
    rst_n = 1'b0; #2; rst_n = 1'b1;
    req = 2'b10; req_write = 2'b00; a1 = 32'h80; prdata = 32'hCAFEF00D;
    tick();
    chk("rr_gnt1", 32'(gnt), 32'h2);
    req = 2'b00;
    tick();
    tick();
    chk("rr_done1", 32'(done), 32'h2);
    chk("rr_rdata1", rdata, 32'hCAFEF00D);
    req = 2'b11; a0 = 32'h84;
    tick();
    chk("rr_gnt_both", 32'(gnt), 32'h1);
    chk("rr_paddr", paddr, 32'h84);
    req = 2'b00;
    tick();
    tick();
    chk("rr_done0", 32'(done), 32'h1);

    // ---- reset asserted while in ACCESS ----
    req = 2'b10; req_write = 2'b10; a1 = 32'h90; d1 = 32'h0; pready = 1'b0;
    tick();
    req = 2'b00;
    tick();
    chk("ra_in_access", 32'(penable), 32'h1);
    #2; rst_n = 1'b0; #1;
    chk("ra_psel", 32'(psel), 32'h0);
    chk("ra_penable", 32'(penable), 32'h0);
    chk("ra_gnt", 32'(gnt), 32'h0);
    chk("ra_done", 32'(done), 32'h0);
    chk("ra_rdata", rdata, 32'h0);
    #3; rst_n = 1'b1; pready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("ra_nodone_%0d", i), 32'(done), 32'h0);
    end

    // ---- back-to-back, both requesting: order 0,1,0,1 ----
    req = 2'b11; req_write = 2'b11; a0 = 32'h20; a1 = 32'h24; d0 = 32'hA0; d1 = 32'hA1;
    for (int e = 1; e <= 9; e++) begin
      tick();
      chk($sformatf("bb_gnt_e%0d", e), 32'(gnt),
          (e == 1 || e == 5) ? 32'h1 : ((e == 3 || e == 7) ? 32'h2 : 32'h0));
      chk($sformatf("bb_done_e%0d", e), 32'(done),
          (e == 3 || e == 7) ? 32'h1 : ((e == 5 || e == 9) ? 32'h2 : 32'h0));
      chk($sformatf("bb_psel_e%0d", e), 32'(psel), (e <= 8) ? 32'h1 : 32'h0);
      chk($sformatf("bb_pen_e%0d", e), 32'(penable), (e % 2 == 0) ? 32'h1 : 32'h0);
      if (e == 7) req = 2'b00;
    end
    chk("bb_rdata_hold", rdata, 32'h0);

`ifdef APB_TIMEOUT_EN
    // ---- timeout: PREADY never rises ----
    req = 2'b01; req_write = 2'b00; a0 = 32'h30; prdata = 32'h5555AAAA; pready = 1'b0;
    tick();
    req = 2'b00;
    chk("to_setup_psel", 32'(psel), 32'h1);
    tick();
    chk("to_acc_pen", 32'(penable), 32'h1);
    // Seed rdata indirectly is not needed: verify 15 quiet wait cycles.
    for (int i = 0; i < 15; i++) begin
      tick();
      chk($sformatf("to_wait_done_%0d", i), 32'(done), 32'h0);
    end
    tick();
    chk("to_done", 32'(done), 32'h1);
    chk("to_err", 32'(err), 32'h1);
    chk("to_rdata", rdata, 32'h0);
    chk("to_psel", 32'(psel), 32'h0);
    tick();
    chk("to_err_clear", 32'(err), 32'h0);
    pready = 1'b1;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
